ucode_seq: RTL

//  Parametrised microcode sequencer for the 65C02 core; next generation of the control sequencer.

---
 rtl/ucode_seq_if.sv | 29 ++
 rtl/ucode_seq.sv | 97 +++++++++
 2 files changed

// File: rtl/ucode_seq_if.sv
// ucode_seq_if: sequencer <-> microcode ROM/datapath signal bundle.
// The master drives the microword fields and CPU inputs; the slave (sequencer) returns upc and status.
interface ucode_seq_if #(
    parameter int UA_W = 10,
    parameter int OP_W = 8
);
    logic            rdy;
    logic            irq;
    logic            nmi;
    logic            i_flag;
    logic            cond;
    logic [OP_W-1:0] opcode;
    logic [2:0]      seq_op;
    logic [UA_W-1:0] seq_tgt;
    logic [UA_W-1:0] upc;
    logic            sync;
    logic [1:0]      int_ack;
    logic            stack_err;

    modport master (
        output rdy, irq, nmi, i_flag, cond, opcode, seq_op, seq_tgt,
        input  upc, sync, int_ack, stack_err
    );

    modport slave (
        input  rdy, irq, nmi, i_flag, cond, opcode, seq_op, seq_tgt,
        output upc, sync, int_ack, stack_err
    );
endinterface

// File: rtl/ucode_seq.sv
// ucode_seq: 65C02 microcode sequencer with call stack, NMI/IRQ dispatch and RDY stall.
// Optional feature macro SEQ_NMI_EN: NMI edge detect, pending latch and NMI_VEC dispatch.
module ucode_seq #(
    parameter int              UA_W        = 10,
    parameter int              OP_W        = 8,
    parameter int              STACK_DEPTH = 2,
    parameter logic [UA_W-1:0] RST_VEC     = 10'h3FC,
    parameter logic [UA_W-1:0] NMI_VEC     = 10'h3F8,
    parameter logic [UA_W-1:0] IRQ_VEC     = 10'h3F4
) (
    input logic        clk,
    input logic        rst_n,
    ucode_seq_if.slave bus
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam logic [2:0] NEXT   = 3'd0;
    localparam logic [2:0] JUMP   = 3'd1;
    localparam logic [2:0] BCOND  = 3'd2;
    localparam logic [2:0] BNCOND = 3'd3;
    localparam logic [2:0] CALL   = 3'd4;
    localparam logic [2:0] RET    = 3'd5;
    localparam logic [2:0] FETCH  = 3'd6;
    localparam logic [2:0] HALT   = 3'd7;

    logic [UA_W-1:0] upc, upc_inc, upc_nxt, op_addr;
    logic [UA_W-1:0] stack [1<<SP_W];
    logic [SP_W-1:0] sp;
    logic [1:0]      int_ack, ack_nxt;
    logic            stack_err, full, empty, push, pop, err, take_irq, nmi_pend;

    always_comb begin
        upc_inc  = upc + UA_W'(1);
        op_addr  = UA_W'(bus.opcode) << (UA_W - OP_W);
        full     = sp == SP_W'(STACK_DEPTH);
        empty    = sp == '0;
        push     = bus.seq_op == CALL && !full;
        pop      = bus.seq_op == RET && !empty;
        err      = (bus.seq_op == CALL && full) || (bus.seq_op == RET && empty);
        take_irq = !nmi_pend && bus.irq && !bus.i_flag;
        ack_nxt  = bus.seq_op == FETCH ? {nmi_pend, take_irq} : 2'b00;
        upc_nxt  = upc_inc;
        case (bus.seq_op)
            NEXT:    upc_nxt = upc_inc;
            JUMP:    upc_nxt = bus.seq_tgt;
            BCOND:   upc_nxt = bus.cond ? bus.seq_tgt : upc_inc;
            BNCOND:  upc_nxt = bus.cond ? upc_inc : bus.seq_tgt;
            CALL:    upc_nxt = bus.seq_tgt;
            RET:     upc_nxt = pop ? stack[sp - SP_W'(1)] : upc_inc;
            FETCH:   upc_nxt = nmi_pend ? NMI_VEC : take_irq ? IRQ_VEC : op_addr;
            HALT:    upc_nxt = upc;
            default: upc_nxt = upc_inc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upc       <= RST_VEC;
            sp        <= '0;
            int_ack   <= 2'b00;
            stack_err <= 1'b0;
        end else if (bus.rdy) begin
            upc       <= upc_nxt;
            sp        <= push ? sp + SP_W'(1) : pop ? sp - SP_W'(1) : sp;
            int_ack   <= ack_nxt;
            stack_err <= stack_err | err;
        end
    end

    // Contents need no reset: sp=0 makes every entry unreachable until rewritten.
    always_ff @(posedge clk) begin
        if (bus.rdy && push) stack[sp] <= upc_inc;
    end

`ifdef SEQ_NMI_EN
    logic nmi_q;
    // A fresh edge wins over the dispatch clear so a back-to-back NMI is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_q    <= 1'b0;
            nmi_pend <= 1'b0;
        end else begin
            nmi_q <= bus.nmi;
            if (bus.nmi && !nmi_q) nmi_pend <= 1'b1;
            else if (bus.sync && nmi_pend) nmi_pend <= 1'b0;
        end
    end
`else
    logic nmi_unused;
    assign nmi_unused = bus.nmi;
    assign nmi_pend   = 1'b0;
`endif

    assign bus.upc       = upc;
    assign bus.sync      = bus.rdy && bus.seq_op == FETCH;
    assign bus.int_ack   = int_ack;
    assign bus.stack_err = stack_err;
endmodule
